// File: rtl/fifo_uart_pkg.sv
// Shared encodings for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN selects the 8E1 frame length.
package fifo_uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_START  = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_PARITY = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        FETCH  = ST_FETCH,
        LOAD   = ST_LOAD,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

    localparam int DATA_BITS = 8;

`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period counter: tick marks the last clk of each bit period,
// clear restarts the period (used on every state entry).
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_WIDTH    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLKS_PER_BIT - 1);

    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from sync_fifo and sends them as 8N1 (8E1 when
// FIFO_UART_TX_PARITY_EN is defined), LSB first.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [2:0]            r_bit;
    logic                  r_tx;
    logic                  r_rd_en;
    logic                  w_tx_nxt;
    logic                  w_tick;
    logic                  w_clear;
    logic                  w_start_ok;
`ifdef FIFO_UART_TX_PARITY_EN
    logic                  r_par;
`endif

    assign w_start_ok = enable && !fifo_empty;
    assign w_clear    = (w_next != r_state) ||
                        (r_state inside {IDLE, FETCH, LOAD});

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_start_ok) w_next = FETCH;
            FETCH: w_next = LOAD;
            LOAD:  w_next = START;
            START: if (w_tick) w_next = DATA;
            DATA: begin
                if (w_tick && (r_bit == LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
                    w_next = PARITY;
`else
                    w_next = STOP;
`endif
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: if (w_tick) w_next = STOP;
`else
            PARITY: w_next = IDLE;
`endif
            STOP:  if (w_tick) w_next = w_start_ok ? FETCH : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // tx is registered, so it is derived from the state being entered
    always_comb begin
        w_tx_nxt = 1'b1;
        unique case (w_next)
            START: w_tx_nxt = 1'b0;
            DATA: begin
                if (r_state != DATA) begin
                    w_tx_nxt = r_shift[0];
                end else if (w_tick) begin
                    w_tx_nxt = r_shift[1];
                end else begin
                    w_tx_nxt = r_tx;
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: w_tx_nxt = r_par;
`endif
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_rd_en <= 1'b0;
            r_shift <= '0;
            r_bit   <= '0;
        end else begin
            r_state <= w_next;
            r_tx    <= w_tx_nxt;
            r_rd_en <= (w_next == FETCH);
            if (r_state == LOAD) begin
                r_shift <= fifo_rd_data;
            end else if ((r_state == DATA) && w_tick) begin
                r_shift <= r_shift >> 1;
            end
            if ((r_state == DATA) && w_tick && (w_next == DATA)) begin
                r_bit <= r_bit + 3'd1;
            end else if (w_next != r_state) begin
                r_bit <= '0;
            end
        end
    end

`ifdef FIFO_UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else if (r_state == LOAD) begin
            r_par <= ^fifo_rd_data;
        end
    end
`endif

    assign fifo_rd_en = r_rd_en;
    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign tx_done    = (r_state == STOP) && w_tick;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a
// behavioural sync_fifo (registered empty and rd_data).
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NB = 11;
    localparam logic [10:0] EXP_A5 = 11'h54A;
`else
    localparam int NB = 10;
    localparam logic [10:0] EXP_A5 = 11'h34A;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    logic [7:0] q[$];
    int         rd_pulses = 0;
    int         underflows = 0;
    int         n_chk = 0;
    int         n_err = 0;

    fifo_uart_tx #(
        .DATA_WIDTH   (8),
        .CLKS_PER_BIT (CPB),
        .CNT_WIDTH    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulses++;
            if (q.size() == 0) underflows++;
            else fifo_rd_data <= q.pop_front();
        end
        if (wr_en) q.push_back(wr_data);
        fifo_empty <= (q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d);
`ifdef FIFO_UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {2'b01, d, 1'b0};
`endif
    endfunction

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Waits for the start bit, then samples each bit mid-period
    task automatic recv(input int drop_at, output logic [10:0] bits,
                        output int wait_n, output int done_cyc,
                        output int done_cnt);
        wait_n = 0;
        bits = '0;
        done_cyc = -1;
        done_cnt = 0;
        while (tx !== 1'b0 && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        check("frame_start", {31'd0, tx}, 32'd0);
        if (tx !== 1'b0) return;
        for (int c = 0; c < NB * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (c == drop_at) enable = 1'b0;
            if (c % CPB == 2) bits[c / CPB] = tx;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        int wn, dc, dn, rd0, bad;

        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_tx_done", {31'd0, tx_done}, 32'd0);
        rst_n = 1'b1;

        // single byte
        enable = 1'b1;
        push(8'hA5);
        recv(-1, bits, wn, dc, dn);
        check("a5_latency", wn, 3);
        check("a5_frame", {21'd0, bits}, {21'd0, EXP_A5});
        check("a5_done_cyc", dc, NB * CPB - 1);
        check("a5_done_cnt", dn, 1);
        @(negedge clk);
        check("a5_busy_after", {31'd0, busy}, 32'd0);
        check("a5_rd_pulses", rd_pulses, 1);

        // burst of three
        enable = 1'b0;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        rd0 = rd_pulses;
        enable = 1'b1;
        recv(-1, bits, wn, dc, dn);
        check("b0_frame", {21'd0, bits}, {21'd0, frame(8'h11)});
        recv(-1, bits, wn, dc, dn);
        check("b1_gap", wn - 1, 2);
        check("b1_frame", {21'd0, bits}, {21'd0, frame(8'h22)});
        recv(-1, bits, wn, dc, dn);
        check("b2_gap", wn - 1, 2);
        check("b2_frame", {21'd0, bits}, {21'd0, frame(8'h33)});
        repeat (3) @(negedge clk);
        check("burst_rd_pulses", rd_pulses - rd0, 3);
        check("burst_empty", {31'd0, fifo_empty}, 32'd1);
        check("burst_busy", {31'd0, busy}, 32'd0);

        // empty FIFO with enable high
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
        end
        check("empty_guard", bad, 0);
        check("underflows", underflows, 0);

        // enable dropped during data bit 3
        enable = 1'b0;
        push(8'h3C);
        push(8'h55);
        enable = 1'b1;
        recv(17, bits, wn, dc, dn);
        check("drop_frame", {21'd0, bits}, {21'd0, frame(8'h3C)});
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
        end
        check("drop_idle", bad, 0);
        check("drop_busy", {31'd0, busy}, 32'd0);
        check("drop_count", q.size(), 1);
        enable = 1'b1;
        recv(-1, bits, wn, dc, dn);
        check("resume_frame", {21'd0, bits}, {21'd0, frame(8'h55)});
        check("resume_count", q.size(), 0);

        // asynchronous reset mid-data
        push(8'hF0);
        wn = 0;
        while (tx !== 1'b0 && wn < 50) begin
            @(negedge clk);
            wn++;
        end
        repeat (6) @(negedge clk);
        check("mid_pre_tx", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_no_resume", bad, 0);

`ifdef FIFO_UART_TX_PARITY_EN
        push(8'h07);
        recv(-1, bits, wn, dc, dn);
        check("p07_parity", {31'd0, bits[9]}, 32'd1);
        check("p07_frame", {21'd0, bits}, {21'd0, 11'h60E});
        check("p07_len", dc + 1, 44);
        push(8'h03);
        recv(-1, bits, wn, dc, dn);
        check("p03_parity", {31'd0, bits[9]}, 32'd0);
        check("p03_frame", {21'd0, bits}, {21'd0, 11'h406});
`endif

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for sync_fifo. It pops bytes from the FIFO one at a time and serialises each one onto a UART TX line as 8N1, LSB first. The optional parity build makes it 8E1. It sits directly downstream of sync_fifo's read port (empty/rd_en/rd_data) and drives the board-level TX pin.

Parameters:
- DATA_WIDTH, 8, width of FIFO word and serial payload; only 8 supported.
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); legal range 2..65535.
- CNT_WIDTH, 16, baud counter width; must satisfy 2^CNT_WIDTH > CLKS_PER_BIT.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  allows new frames to start; never aborts a frame in flight.
- fifo_empty  input  1  sync_fifo empty flag.
- fifo_rd_data  input  DATA_WIDTH  sync_fifo rd_data; registered, valid the cycle after rd_en.
- fifo_rd_en  output  1  single-cycle pop strobe to sync_fifo.
- tx  output  1  serial line; idle high.
- busy  output  1  high from FETCH through end of STOP.
- tx_done  output  1  one-cycle pulse on the last clk of the stop bit.

Behaviour:
- Reset is asynchronous and active-low and applies immediately, including mid-frame. Reset values: tx=1, fifo_rd_en=0, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0.
- No partial frame resumes after reset. A popped byte that was not sent is lost.
- FSM states and transitions:
  - IDLE: go to FETCH when enable=1 and fifo_empty=0.
  - FETCH: exactly 1 cycle. fifo_rd_en=1 in this cycle only.
  - LOAD: exactly 1 cycle. Capture fifo_rd_data into the shift register. Compute parity if built in.
  - START: CLKS_PER_BIT cycles, tx=0.
  - DATA: 8*CLKS_PER_BIT cycles. tx = shift[0]; shift right once per bit period.
  - PARITY: only with the macro; CLKS_PER_BIT cycles.
  - STOP: CLKS_PER_BIT cycles, tx=1. tx_done=1 on the final cycle. Then go to FETCH if enable=1 and fifo_empty=0, else to IDLE.
- fifo_rd_en and tx are registered Moore outputs. fifo_rd_en is never asserted while fifo_empty=1, so the FIFO never sees an underflow read.
- Output timing:
  - tx falls on the clk edge that enters START.
  - Back-to-back frames have exactly 2 clk of idle-high gap (FETCH and LOAD) between the end of stop and the start bit.
  - Latency from fifo_empty falling (in IDLE, enable=1) to tx falling is 3 clk edges.
- Baud counter counts 0..CLKS_PER_BIT-1. The bit-index counter covers 0..7 and wraps only on state change.
- enable deasserted mid-frame: the current frame completes; no further FETCH occurs.
- fifo_empty toggling mid-frame has no effect.

Optional Feature:
- Macro FIFO_UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted between DATA and STOP. tx = even parity (XOR of the 8 data bits). The frame is 11 bits.
- Undefined: the PARITY state is absent and the frame is 10 bits. Parity logic must not be synthesised.

Decomposition:
- Package fifo_uart_pkg holds:
  - state encoding localparams (IDLE=0, FETCH=1, LOAD=2, START=3, DATA=4, PARITY=5, STOP=6);
  - frame bit counts (FRAME_BITS = 10, or 11 with parity).
- One sub-module, baud_tick_gen (parameter CLKS_PER_BIT):
  - ports: clk, rst_n, clear in, tick out;
  - tick pulses on the last cycle of each bit period;
  - clear restarts the count on state entry.

Test Plan (CLKS_PER_BIT=4, driving a real sync_fifo instance):
- Reset: hold rst_n=0 for 3 clk -> tx=1, busy=0, fifo_rd_en=0, tx_done=0. Assert rst_n=0 mid-DATA -> tx=1 in the same timestep, state IDLE.
- Single byte: write 8'hA5, enable=1 -> fifo_rd_en high 1 cycle. tx sequence per 4-clk bit: 0,1,0,1,0,0,1,0,1,1. tx_done pulse at clk 40 after START entry; busy low afterward.
- Burst: write 8'h11,8'h22,8'h33 -> three frames, each with exactly 2 idle-high clk between them. Exactly 3 fifo_rd_en pulses; FIFO empty=1 at end.
- Empty/underflow guard: enable=1 with FIFO empty for 50 clk -> fifo_rd_en never asserted, tx=1 throughout.
- enable drop: deassert enable during the DATA bit-3 period of 8'h3C with 8'h55 still queued -> 8'h3C frame completes, 8'h55 stays in FIFO (data_count=1). Re-assert enable -> 8'h55 is sent.
- With FIFO_UART_TX_PARITY_EN: send 8'h07 -> parity bit = 1, frame = 44 clk. Send 8'h03 -> parity bit = 0.
